// File: rtl/gpio_pulpino_mailbox_if.sv
// Host/core signal bundle for gpio_pulpino_mailbox. The slave modport is the mailbox side;
// the master modport is the register block plus the PULPino GPIO side.
interface gpio_pulpino_mailbox_if #(
   parameter int pDATA_WIDTH = 8,
   parameter int pFIFO_DEPTH = 16
);
   localparam int LVL_W = $clog2(pFIFO_DEPTH) + 1;

   logic                   host_wr_valid;
   logic [pDATA_WIDTH-1:0] host_wr_data;
   logic                   host_wr_ready;
   logic                   host_rd_req;
   logic [pDATA_WIDTH-1:0] host_rd_data;
   logic                   host_rd_valid;
   logic [LVL_W-1:0]       tx_level;
   logic [LVL_W-1:0]       rx_level;
   logic                   tx_drop;
   logic                   rd_underflow;
   logic                   clear_flags;
   logic [pDATA_WIDTH-1:0] core_tx_data;
   logic                   core_tx_req;
   logic                   core_tx_ack;
   logic [pDATA_WIDTH-1:0] core_rx_data;
   logic                   core_rx_req;
   logic                   core_rx_ack;
   logic                   timeout;

   modport slave (
      input  host_wr_valid, host_wr_data, host_rd_req, clear_flags,
      input  core_tx_ack, core_rx_data, core_rx_req,
      output host_wr_ready, host_rd_data, host_rd_valid, tx_level, rx_level,
      output tx_drop, rd_underflow, core_tx_data, core_tx_req, core_rx_ack, timeout
   );

   modport master (
      output host_wr_valid, host_wr_data, host_rd_req, clear_flags,
      output core_tx_ack, core_rx_data, core_rx_req,
      input  host_wr_ready, host_rd_data, host_rd_valid, tx_level, rx_level,
      input  tx_drop, rd_underflow, core_tx_data, core_tx_req, core_rx_ack, timeout
   );
endinterface

// File: rtl/gpio_pulpino_mailbox.sv
// Two-channel FIFO-buffered GPIO mailbox between the register block and PULPino, toggle req/ack.
// Optional TX-ack watchdog enabled by defining GPIO_MBOX_TIMEOUT_EN.
module gpio_pulpino_mailbox #(
   parameter int pDATA_WIDTH = 8,
   parameter int pFIFO_DEPTH = 16,
   parameter int pTIMEOUT    = 1024
) (
   input logic                   clk,
   input logic                   reset_i,
   gpio_pulpino_mailbox_if.slave mbox
);
   localparam int PTR_W = $clog2(pFIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(pFIFO_DEPTH);

   if (pDATA_WIDTH < 1 || pDATA_WIDTH > 24 || pFIFO_DEPTH < 2 ||
       (pFIFO_DEPTH & (pFIFO_DEPTH - 1)) != 0 || pTIMEOUT < 1) begin : g_bad_cfg
      $error("gpio_pulpino_mailbox: unsupported parameter combination");
   end

   typedef enum logic {TX_IDLE, TX_WAIT} tx_state_e;

   // core-side inputs pass one capture register before any use
   logic                   tx_ack_s_q, tx_ack_s_d;
   logic                   rx_req_s_q, rx_req_s_d;
   logic [pDATA_WIDTH-1:0] rx_data_s_q, rx_data_s_d;

   logic [pDATA_WIDTH-1:0] tx_mem_q [pFIFO_DEPTH];
   logic [PTR_W-1:0]       tx_wr_ptr_q, tx_wr_ptr_d;
   logic [PTR_W-1:0]       tx_rd_ptr_q, tx_rd_ptr_d;
   logic [LVL_W-1:0]       tx_level_q, tx_level_d;
   logic                   tx_full, tx_empty, tx_push, tx_pop;

   logic [pDATA_WIDTH-1:0] rx_mem_q [pFIFO_DEPTH];
   logic [PTR_W-1:0]       rx_wr_ptr_q, rx_wr_ptr_d;
   logic [PTR_W-1:0]       rx_rd_ptr_q, rx_rd_ptr_d;
   logic [LVL_W-1:0]       rx_level_q, rx_level_d;
   logic                   rx_full, rx_empty, rx_push, rx_pop;

   tx_state_e              tx_state_q, tx_state_d;
   logic                   core_tx_req_q, core_tx_req_d;
   logic [pDATA_WIDTH-1:0] core_tx_data_q, core_tx_data_d;
   logic                   core_rx_ack_q, core_rx_ack_d;
   logic [pDATA_WIDTH-1:0] host_rd_data_q, host_rd_data_d;
   logic                   host_rd_valid_q, host_rd_valid_d;
   logic                   tx_drop_q, tx_drop_d;
   logic                   rd_underflow_q, rd_underflow_d;

`ifdef GPIO_MBOX_TIMEOUT_EN
   localparam int CNT_W = $clog2(pTIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(pTIMEOUT - 1);
   localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(pTIMEOUT);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             timeout_q, timeout_d;
   logic             timeout_evt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == TMO_MAX) ? v : v + CNT_W'(1);
   endfunction
`endif

   always_comb begin
      tx_ack_s_d  = mbox.core_tx_ack;
      rx_req_s_d  = mbox.core_rx_req;
      rx_data_s_d = mbox.core_rx_data;
   end

   always_comb begin
      tx_full  = (tx_level_q == FULL_LVL);
      tx_empty = (tx_level_q == '0);
      rx_full  = (rx_level_q == FULL_LVL);
      rx_empty = (rx_level_q == '0);
   end

   // TX FSM: one word on the GPIO lines at a time, frozen until the core echoes the req phase
   always_comb begin
      tx_state_d     = tx_state_q;
      tx_pop         = 1'b0;
      core_tx_req_d  = core_tx_req_q;
      core_tx_data_d = core_tx_data_q;
`ifdef GPIO_MBOX_TIMEOUT_EN
      timeout_evt    = 1'b0;
`endif
      case (tx_state_q)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_pop         = 1'b1;
               core_tx_data_d = tx_mem_q[tx_rd_ptr_q];
               core_tx_req_d  = ~core_tx_req_q;
               tx_state_d     = TX_WAIT;
            end
         end
         TX_WAIT: begin
            if (tx_ack_s_q == core_tx_req_q) begin
               tx_state_d = TX_IDLE;
`ifdef GPIO_MBOX_TIMEOUT_EN
            end else if (tmo_cnt_q == TMO_LAST) begin
               timeout_evt = 1'b1;
               tx_state_d  = TX_IDLE;
`endif
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_push     = mbox.host_wr_valid && !tx_full;
      tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(tx_push);
      tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(tx_pop);
      tx_level_d  = tx_level_q + LVL_W'(tx_push) - LVL_W'(tx_pop);
   end

   // RX: a new core phase is taken only when there is room, otherwise the ack is withheld
   always_comb begin
      rx_push         = (rx_req_s_q != core_rx_ack_q) && !rx_full;
      rx_pop          = mbox.host_rd_req && !rx_empty;
      core_rx_ack_d   = core_rx_ack_q ^ rx_push;
      rx_wr_ptr_d     = rx_wr_ptr_q + PTR_W'(rx_push);
      rx_rd_ptr_d     = rx_rd_ptr_q + PTR_W'(rx_pop);
      rx_level_d      = rx_level_q + LVL_W'(rx_push) - LVL_W'(rx_pop);
      host_rd_data_d  = rx_pop ? rx_mem_q[rx_rd_ptr_q] : host_rd_data_q;
      host_rd_valid_d = rx_pop;
   end

   always_comb begin
      tx_drop_d      = (mbox.host_wr_valid && tx_full) || (tx_drop_q && !mbox.clear_flags);
      rd_underflow_d = (mbox.host_rd_req && rx_empty) || (rd_underflow_q && !mbox.clear_flags);
   end

`ifdef GPIO_MBOX_TIMEOUT_EN
   always_comb begin
      tmo_cnt_d = (tx_state_q == TX_WAIT) ? sat_inc(tmo_cnt_q) : '0;
      timeout_d = timeout_evt || (timeout_q && !mbox.clear_flags);
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign mbox.timeout = timeout_q;
`else
   assign mbox.timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset_i) begin
         tx_ack_s_q      <= 1'b0;
         rx_req_s_q      <= 1'b0;
         tx_wr_ptr_q     <= '0;
         tx_rd_ptr_q     <= '0;
         tx_level_q      <= '0;
         rx_wr_ptr_q     <= '0;
         rx_rd_ptr_q     <= '0;
         rx_level_q      <= '0;
         tx_state_q      <= TX_IDLE;
         core_tx_req_q   <= 1'b0;
         core_tx_data_q  <= '0;
         core_rx_ack_q   <= 1'b0;
         host_rd_data_q  <= '0;
         host_rd_valid_q <= 1'b0;
         tx_drop_q       <= 1'b0;
         rd_underflow_q  <= 1'b0;
      end else begin
         tx_ack_s_q      <= tx_ack_s_d;
         rx_req_s_q      <= rx_req_s_d;
         tx_wr_ptr_q     <= tx_wr_ptr_d;
         tx_rd_ptr_q     <= tx_rd_ptr_d;
         tx_level_q      <= tx_level_d;
         rx_wr_ptr_q     <= rx_wr_ptr_d;
         rx_rd_ptr_q     <= rx_rd_ptr_d;
         rx_level_q      <= rx_level_d;
         tx_state_q      <= tx_state_d;
         core_tx_req_q   <= core_tx_req_d;
         core_tx_data_q  <= core_tx_data_d;
         core_rx_ack_q   <= core_rx_ack_d;
         host_rd_data_q  <= host_rd_data_d;
         host_rd_valid_q <= host_rd_valid_d;
         tx_drop_q       <= tx_drop_d;
         rd_underflow_q  <= rd_underflow_d;
      end
   end

   // payload storage carries no reset; the pointers alone define what is valid
   always_ff @(posedge clk) begin
      rx_data_s_q <= rx_data_s_d;
      if (tx_push) tx_mem_q[tx_wr_ptr_q] <= mbox.host_wr_data;
      if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data_s_q;
   end

   assign mbox.host_wr_ready = !tx_full;
   assign mbox.host_rd_data  = host_rd_data_q;
   assign mbox.host_rd_valid = host_rd_valid_q;
   assign mbox.tx_level      = tx_level_q;
   assign mbox.rx_level      = rx_level_q;
   assign mbox.tx_drop       = tx_drop_q;
   assign mbox.rd_underflow  = rd_underflow_q;
   assign mbox.core_tx_data  = core_tx_data_q;
   assign mbox.core_tx_req   = core_tx_req_q;
   assign mbox.core_rx_ack   = core_rx_ack_q;
endmodule
